// File: rtl/blram_arbiter.sv
// blram_arbiter: shares one single-port blram (1-cycle registered read) between
// master 0 (CPU) and master 1 (loader/debug). One access per cycle, with a burst
// limit so a contested master cannot be starved for more than MAX_BURST cycles.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined, an uncontested-owner
// tie goes to the master that was not granted last; otherwise master 0 wins ties.
module blram_arbiter #(
  parameter int SIZE      = 14,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [SIZE-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [SIZE-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  owner_t          owner_q, owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            last_q, last_d;
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic [SIZE-1:0] addr_q, addr_d;

  logic owner_full;
  logic tie_m1;

  // last_q: 0 = master 0 was granted most recently, 1 = master 1
  assign owner_full = (burst_cnt_q == MAX_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_m1 = ~last_q;
`else
  assign tie_m1 = 1'b0;
`endif

  // Grant decision: lone requester always wins; contested cycles honour the burst limit
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && !m1_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req && !m0_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req && m1_req) begin
        unique case (owner_q)
          OWN_M0: begin
            if (owner_full) m1_gnt = 1'b1;
            else            m0_gnt = 1'b1;
          end
          OWN_M1: begin
            if (owner_full) m0_gnt = 1'b1;
            else            m1_gnt = 1'b1;
          end
          default: begin
            if (tie_m1) m1_gnt = 1'b1;
            else        m0_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  // Steer the granted master onto the blram port; idle cycles keep the last address
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Next ownership, burst count, round-robin pointer and read-valid pipeline
  always_comb begin
    owner_d     = OWN_NONE;
    burst_cnt_d = '0;
    last_d      = last_q;
    addr_d      = addr_q;
    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
    if (m0_gnt) begin
      owner_d     = OWN_M0;
      last_d      = 1'b0;
      addr_d      = m0_addr;
      if (owner_q != OWN_M0)  burst_cnt_d = CW'(1);
      else if (owner_full)    burst_cnt_d = burst_cnt_q;
      else                    burst_cnt_d = burst_cnt_q + CW'(1);
    end else if (m1_gnt) begin
      owner_d     = OWN_M1;
      last_d      = 1'b1;
      addr_d      = m1_addr;
      if (owner_q != OWN_M1)  burst_cnt_d = CW'(1);
      else if (owner_full)    burst_cnt_d = burst_cnt_q;
      else                    burst_cnt_d = burst_cnt_q + CW'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      addr_q      <= addr_d;
    end
  end

  // A read granted just before reset is dropped while reset is asserted
  assign m0_rvalid = m0_rvalid_q & ~rst;
  assign m1_rvalid = m1_rvalid_q & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_blram_arbiter.sv
// tb_blram_arbiter: directed stimulus for blram_arbiter against a behavioural
// blram and a transaction-level reference model (grant streaks, model memory).
module tb_blram_arbiter;

  localparam int SIZE      = 14;
  localparam int MAX_BURST = 8;

  logic            clk;
  logic            rst;
  logic            m0_req, m0_we, m1_req, m1_we;
  logic [SIZE-1:0] m0_addr, m1_addr;
  logic [31:0]     m0_wdata, m1_wdata;
  logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;
  bit done     = 0;

  blram_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port blram with registered read
  logic [31:0] ram_mem [0:(1<<SIZE)-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q0, input logic w0,
                               input int a0, input logic [31:0] d0,
                               input logic q1, input logic w1,
                               input int a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = SIZE'(a0); m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = SIZE'(a1); m1_wdata = d1;
  endtask

  // Reference model: memory contents, grant streak, last winner, pending reads
  logic [31:0] model_mem [int];
  int  s_master = -1;
  int  s_len    = 0;
  int  m_last   = 1;
  bit  pend0 = 0, pend1 = 0;
  logic [31:0] pend_data0 = '0, pend_data1 = '0;
  bit  have_addr = 0;
  int  held_addr = 0;

  function automatic logic [31:0] model_read(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    return 32'h0;
  endfunction

  int  winner;
  int  tie;
  bit  e_g0, e_g1;

  // Every cycle: derive the expected outputs from the model, compare, then advance it
  always @(negedge clk) begin
    if (!done) begin
`ifdef ARB_ROUND_ROBIN_EN
      tie = (m_last == 1) ? 0 : 1;
`else
      tie = 0;
`endif
      winner = -1;
      if (!rst) begin
        if (m0_req && !m1_req)      winner = 0;
        else if (m1_req && !m0_req) winner = 1;
        else if (m0_req && m1_req) begin
          if (s_master < 0)            winner = tie;
          else if (s_len >= MAX_BURST) winner = 1 - s_master;
          else                         winner = s_master;
        end
      end
      e_g0 = (winner == 0);
      e_g1 = (winner == 1);

      checkOutput("m0_gnt", {31'b0, m0_gnt}, {31'b0, e_g0});
      checkOutput("m1_gnt", {31'b0, m1_gnt}, {31'b0, e_g1});
      checkOutput("gnt_exclusive", {31'b0, m0_gnt & m1_gnt}, 32'h0);
      checkOutput("ram_we", {31'b0, ram_we},
                  {31'b0, (e_g0 && m0_we) || (e_g1 && m1_we)});
      if (e_g0) begin
        checkOutput("ram_addr_m0", 32'(ram_addr), 32'(m0_addr));
        if (m0_we) checkOutput("ram_wdata_m0", ram_wdata, m0_wdata);
      end else if (e_g1) begin
        checkOutput("ram_addr_m1", 32'(ram_addr), 32'(m1_addr));
        if (m1_we) checkOutput("ram_wdata_m1", ram_wdata, m1_wdata);
      end else if (!rst && have_addr) begin
        checkOutput("ram_addr_hold", 32'(ram_addr), 32'(held_addr));
      end
      checkOutput("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, pend0 && !rst});
      checkOutput("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, pend1 && !rst});
      checkOutput("m0_rdata", m0_rdata, (pend0 && !rst) ? pend_data0 : 32'h0);
      checkOutput("m1_rdata", m1_rdata, (pend1 && !rst) ? pend_data1 : 32'h0);

      if (rst) begin
        s_master = -1; s_len = 0; m_last = 1;
        pend0 = 0; pend1 = 0; have_addr = 0;
      end else begin
        pend0 = e_g0 && !m0_we;
        pend1 = e_g1 && !m1_we;
        if (e_g0) begin
          pend_data0 = model_read(int'(m0_addr));
          if (m0_we) model_mem[int'(m0_addr)] = m0_wdata;
          held_addr = int'(m0_addr);
        end
        if (e_g1) begin
          pend_data1 = model_read(int'(m1_addr));
          if (m1_we) model_mem[int'(m1_addr)] = m1_wdata;
          held_addr = int'(m1_addr);
        end
        if (winner >= 0) begin
          have_addr = 1;
          if (winner == s_master) s_len = (s_len < MAX_BURST) ? s_len + 1 : MAX_BURST;
          else s_len = 1;
          s_master = winner;
          m_last   = winner;
        end else begin
          s_master = -1;
          s_len    = 0;
        end
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations
  initial begin
    int exp_second;
    for (int i = 0; i < (1<<SIZE); i++) ram_mem[i] = 32'h0;
    ram_mem[69] = 32'h1;
    model_mem[69] = 32'h1;
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = '0; m0_wdata = 32'h1234;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = '0; m1_wdata = 32'h5678;

    // Reset held with both masters requesting: nothing may reach the blram
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
      checkOutput("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
      checkOutput("rst_ram_we", {31'b0, ram_we}, 32'h0);
      checkOutput("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
      if (i < 9) applyStimulus(1, 1, 1, 0, 32'h1234, 1, 1, 0, 32'h5678);
    end

    // Lone master 0 read of address 69
    applyStimulus(0, 1, 0, 69, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("read69_gnt", {31'b0, m0_gnt}, 32'h1);
    checkOutput("read69_addr", 32'(ram_addr), 32'd69);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("read69_rvalid", {31'b0, m0_rvalid}, 32'h1);
    checkOutput("read69_rdata", m0_rdata, 32'h1);
    checkOutput("read69_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);

    // Master 1 writes, master 0 reads the same word the next cycle
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 50, 32'hDEAD);
    @(negedge clk);
    checkOutput("wr50_gnt", {31'b0, m1_gnt}, 32'h1);
    checkOutput("wr50_we", {31'b0, ram_we}, 32'h1);
    applyStimulus(0, 1, 0, 50, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd50_gnt", {31'b0, m0_gnt}, 32'h1);
    checkOutput("wr50_no_rvalid", {31'b0, m1_rvalid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd50_rdata", m0_rdata, 32'hDEAD);

    // Continuous contention: bursts of MAX_BURST alternate, starting with M0
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 0, i, 0, 1, 0, 100 + i, 0);
      @(negedge clk);
      checkOutput("burst_m0_gnt", {31'b0, m0_gnt}, {31'b0, ((i / 8) % 2) == 0});
      checkOutput("burst_m1_gnt", {31'b0, m1_gnt}, {31'b0, ((i / 8) % 2) == 1});
    end

    // Lone requester ignores the burst limit; contender then wins against a full streak
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 200 + i, 0);
      @(negedge clk);
      checkOutput("lone_m1_gnt", {31'b0, m1_gnt}, 32'h1);
    end
    applyStimulus(0, 1, 0, 7, 0, 1, 0, 300, 0);
    @(negedge clk);
    checkOutput("saturated_switch_m0", {31'b0, m0_gnt}, 32'h1);
    applyStimulus(0, 1, 0, 8, 0, 1, 0, 300, 0);
    @(negedge clk);
    checkOutput("saturated_keep_m0", {31'b0, m0_gnt}, 32'h1);

    // Tie-break from idle, twice, after a reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 10, 0, 1, 0, 11, 0);
    @(negedge clk);
    checkOutput("tie1_m0_gnt", {31'b0, m0_gnt}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 12, 0, 1, 0, 13, 0);
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_second = 1;
`else
    exp_second = 0;
`endif
    checkOutput("tie2_m1_gnt", {31'b0, m1_gnt}, {31'b0, exp_second == 1});
    checkOutput("tie2_m0_gnt", {31'b0, m0_gnt}, {31'b0, exp_second == 0});

    // Reset right after a granted read: no rvalid, state back to reset values
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 69, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre_rst_gnt", {31'b0, m0_gnt}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_drop_rvalid", {31'b0, m0_rvalid}, 32'h0);
    checkOutput("rst_drop_rdata", m0_rdata, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_drop_rvalid2", {31'b0, m0_rvalid}, 32'h0);
    applyStimulus(0, 1, 0, 69, 0, 1, 0, 70, 0);
    @(negedge clk);
    checkOutput("post_rst_tie_m0", {31'b0, m0_gnt}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_rst_rdata", m0_rdata, 32'h1);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
